// File: rtl/reg_bank8x8_pkg.sv
// Shared definitions for the general-purpose register bank and the
// instruction decoder that drives its op/addr inputs.
//   op_e   : two-bit operation code carried on the op bus
//   NREGS  : number of registers in the bank
//   IDX_W  : width of the register index (addr)
package reg_bank8x8_pkg;

  localparam int NREGS = 8;
  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

endpackage : reg_bank8x8_pkg

// File: rtl/reg_bank8x8_cell8.sv
// One register of the bank.
// It holds a WIDTH-bit value and computes, from the current value and the
// requested op, the next value plus the carry/zero that would result.
// The value is committed only when en_i is high; flag registers live in the
// top level.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : commit the computed next value at the rising edge
//   op_i       : operation (NOP/LOAD/INC/DEC)
//   wr_data_i  : load data
//   value_o    : current register contents (direct flop output)
//   nxt_c_o    : carry/borrow the op would produce (0 for LOAD/NOP)
//   nxt_z_o    : next value is zero
module reg_cell8
  import reg_bank8x8_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] value_o,
  output logic             nxt_c_o,
  output logic             nxt_z_o
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH:0]   sum;

  // The extra top bit of sum is the carry for INC and the borrow for DEC:
  // 0 - 1 in WIDTH+1 bits leaves the top bit set.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default on any branch infers a latch.
    value_d = value_q;
    sum     = '0;
    nxt_c_o = 1'b0;
    case (op_i)
      OP_LOAD: value_d = wr_data_i;
      OP_INC: begin
        sum     = {1'b0, value_q} + ONE;
        value_d = sum[WIDTH-1:0];
        nxt_c_o = sum[WIDTH];
      end
      OP_DEC: begin
        sum     = {1'b0, value_q} - ONE;
        value_d = sum[WIDTH-1:0];
        nxt_c_o = sum[WIDTH];
      end
      default: ;
    endcase
    nxt_z_o = (value_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of evaluation order.
    if (!rst_n) begin
      value_q <= RST_VAL;
    end else if (en_i) begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule : reg_cell8

// File: rtl/reg_bank8x8.sv
// Eight-entry general-purpose register bank feeding the operand select mux.
// One LOAD/INC/DEC per cycle on the addressed register, with registered
// carry/zero flags and a one-cycle acknowledge. Optionally r0 is read-only.
//   clk, rst_n        : clock, asynchronous active-low reset
//   op_valid          : request strobe (always accepted)
//   op, addr, wr_data : operation, target index, load data
//   r0..r7            : register contents, direct flop outputs
//   flag_c, flag_z    : carry/borrow of last INC/DEC, zero of last write
//   op_ack            : pulses the cycle after every accepted request
//   op_err            : pulses with op_ack when a write targeted protected r0
module reg_bank8x8
  import reg_bank8x8_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               PROT_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [IDX_W-1:0] addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic             flag_c,
  output logic             flag_z,
  output logic             op_ack,
  output logic             op_err
);

  op_e              op_s;
  logic             prot_hit;
  logic             wr_ok;
  logic [NREGS-1:0] en;
  logic [NREGS-1:0] cell_c;
  logic [NREGS-1:0] cell_z;
  logic [WIDTH-1:0] cell_val [NREGS];

  logic flag_c_q, flag_c_d;
  logic flag_z_q, flag_z_d;
  logic op_ack_q, op_ack_d;
  logic op_err_q, op_err_d;

  assign op_s     = op_e'(op);
  // A non-NOP aimed at r0 while r0 is protected is acknowledged but dropped.
  assign prot_hit = PROT_R0 && (addr == '0) && (op_s != OP_NOP);
  assign wr_ok    = op_valid && (op_s != OP_NOP) && !prot_hit;

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    assign en[i] = wr_ok && (addr == idx_t'(i));

    reg_cell8 #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (en[i]),
      .op_i      (op_s),
      .wr_data_i (wr_data),
      .value_o   (cell_val[i]),
      .nxt_c_o   (cell_c[i]),
      .nxt_z_o   (cell_z[i])
    );
  end

  // Flags follow the addressed cell only when its write actually happens;
  // LOAD leaves the carry alone.
  always_comb begin
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    op_ack_d = op_valid;
    op_err_d = op_valid && prot_hit;
    if (wr_ok) begin
      flag_z_d = cell_z[addr];
      if (op_s != OP_LOAD) begin
        flag_c_d = cell_c[addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_c_q <= 1'b0;
      flag_z_q <= (RST_VAL == '0);
      op_ack_q <= 1'b0;
      op_err_q <= 1'b0;
    end else begin
      flag_c_q <= flag_c_d;
      flag_z_q <= flag_z_d;
      op_ack_q <= op_ack_d;
      op_err_q <= op_err_d;
    end
  end

  assign r0     = cell_val[0];
  assign r1     = cell_val[1];
  assign r2     = cell_val[2];
  assign r3     = cell_val[3];
  assign r4     = cell_val[4];
  assign r5     = cell_val[5];
  assign r6     = cell_val[6];
  assign r7     = cell_val[7];
  assign flag_c = flag_c_q;
  assign flag_z = flag_z_q;
  assign op_ack = op_ack_q;
  assign op_err = op_err_q;

endmodule : reg_bank8x8

// File: doc/reg_bank8x8.md
Name: reg_bank8x8

Overview:
- Eight-entry, 8-bit general-purpose register bank in the processor datapath.
- Sits directly upstream of the 8-way, 8-bit operand select mux. Its outputs r0..r7 drive the mux inputs in0..in7.
- Takes one operation per cycle on a selected register: load, increment or decrement. Produces registered carry/zero flags and a one-cycle acknowledge.

Parameters:
- WIDTH, 8, data width of each register. The downstream mux fixes this at 8.
- RST_VAL, 8'h00, value loaded into every register on reset.
- PROT_R0, 1, when 1, r0 is read-only and always holds RST_VAL.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op_valid  input  1  operation request, sampled on rising clk.
- op  input  2  operation: 00 NOP, 01 LOAD, 10 INC, 11 DEC.
- addr  input  3  target register index 0..7.
- wr_data  input  8  data for LOAD.
- r0..r7  output  8 each  current register contents. Eight separate ports, wired to mux in0..in7.
- flag_c  output  1  carry/borrow from the last INC/DEC.
- flag_z  output  1  result-is-zero from the last LOAD/INC/DEC.
- op_ack  output  1  one-cycle pulse confirming an accepted operation.
- op_err  output  1  one-cycle pulse flagging a write attempt to protected r0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - r0..r7 = RST_VAL.
  - flag_c = 0; flag_z = 1 if RST_VAL == 0, else 0.
  - op_ack = 0, op_err = 0.
  - Takes effect immediately, mid-operation included. A request sampled on the release edge is still processed normally.
- No handshake backpressure: the bank is always ready. Every cycle with op_valid=1 is an accepted request.
- Accepted request at edge N:
  - Target register and flags update at edge N.
  - Visible on r<addr>/flags during cycle N+1; latency 1.
  - op_ack=1 for exactly cycle N+1.
- op_valid=1 with op=NOP: no register/flag change; op_ack still pulses.
- LOAD: r[addr] = wr_data; flag_z = (wr_data == 0); flag_c unchanged.
- INC: computed in 9 bits, {c, res} = r[addr] + 1.
  - r[addr] = res; flag_c = c; flag_z = (res == 0).
  - 8'hFF wraps to 8'h00 with c=1, z=1.
- DEC: {b, res} = r[addr] - 1.
  - r[addr] = res; flag_c = b (borrow); flag_z = (res == 0).
  - 8'h00 wraps to 8'hFF with c=1, z=0.
- Protected r0 (PROT_R0=1, addr=0, op != NOP):
  - r0 and flags unchanged.
  - op_ack=1 and op_err=1 in cycle N+1.
- op_valid=0: all state held; op_ack=0, op_err=0 next cycle.
- Back-to-back requests to the same register chain correctly: each sees the result of the previous edge. INC,INC on 8'h05 gives 8'h07 after two edges.
- Registers not addressed are never modified.
- r0..r7 are direct register outputs with no combinational path from inputs, so the downstream mux sees stable values for the full cycle.

Decomposition:
- Shared package:
  - op-code constants OP_NOP=2'b00, OP_LOAD=2'b01, OP_INC=2'b10, OP_DEC=2'b11.
  - Register-count constant NREGS=8 and index width 3.
  - Shared with the instruction decoder that drives op/addr.
- Sub-module: reg_cell8, one 8-bit register.
  - Inputs: local enable, op, wr_data.
  - Outputs: value, next carry, next zero.
  - Instantiated 8 times; the top level decodes addr to the enables and muxes carry/zero from the addressed cell into the flag registers.

Test Plan:
- Reset with RST_VAL=0: release rst_n -> r0..r7=8'h00, flag_z=1, flag_c=0, op_ack=0.
- LOAD r3=8'hA5 -> next cycle r3=8'hA5, flag_z=0, op_ack=1 for one cycle, others 8'h00. Then INC r3 twice back-to-back -> r3=8'hA7.
- LOAD r7=8'hFF, INC r7 -> r7=8'h00, flag_c=1, flag_z=1. Then DEC r7 -> r7=8'hFF, flag_c=1, flag_z=0.
- PROT_R0=1: LOAD r0=8'h42 -> r0 stays 8'h00, flags unchanged, op_ack=1 and op_err=1 for one cycle.
- rst_n asserted mid-stream after r5=8'h10 -> r5=8'h00 immediately, without waiting for a clk edge. A LOAD sampled on the release edge takes effect.
- Idle cycles (op_valid=0) and NOP requests -> no register/flag change; op_ack pulses only for the NOP.
